// File: rtl/mem_responder.sv
// Byte-wide memory slave answering a four-phase req/ack handshake after a fixed number of
// wait states, with a side-band preload port that is honoured only while idle.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              ack,
    output logic [7:0]        rdata,
    output logic              err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        RELEASE
    } state_t;

    state_t              state;
    logic [3:0]          count;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [7:0]          lat_wdata;
    logic [7:0]          mem [DEPTH];

    logic                mem_wr;
    logic [IDX_W-1:0]    wr_idx;
    logic [7:0]          wr_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
    endfunction

    // One write port shared by preload (IDLE) and the transaction access (last WAIT edge).
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        mem_wr  = 1'b0;
        wr_idx  = lat_addr[IDX_W-1:0];
        wr_data = lat_wdata;
        if (!reset) begin
            if (state == IDLE && load_en) begin
                mem_wr  = in_range(load_addr);
                wr_idx  = load_addr[IDX_W-1:0];
                wr_data = load_data;
            end else if (state == WAIT && count == 4'd0) begin
                mem_wr = lat_we && in_range(lat_addr);
            end
        end
    end

    // NOTE: storage deliberately has no reset branch; contents survive reset and a write
    // scheduled on a reset edge is suppressed by the gating above instead.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_idx] <= wr_data;
    end

    // Request fields are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && !load_en && req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 8'h00;
            busy  <= 1'b0;
            count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!load_en && req) begin
                        count <= 4'(WAIT_CYCLES);
                        busy  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        ack <= 1'b1;
                        err <= !in_range(lat_addr);
                        if (!lat_we && in_range(lat_addr)) rdata <= mem[lat_addr[IDX_W-1:0]];
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        err   <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: two instances (DEPTH=128/WAIT=2 and DEPTH=256/WAIT=0)
// share one stimulus bus selected by sel, each checked against a byte-array reference model.
module tb_mem_responder;

    localparam int DEPTH_A = 128;
    localparam int WAIT_A  = 2;
    localparam int DEPTH_B = 256;
    localparam int WAIT_B  = 0;

    logic       clk;
    logic       reset, req, we, load_en, sel;
    logic [7:0] addr, wdata, load_addr, load_data;
    logic       ack_a, err_a, busy_a, ack_b, err_b, busy_b;
    logic [7:0] rdata_a, rdata_b;
    logic       ack, err, busy;
    logic [7:0] rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [2][256];
    logic [7:0] rd_m  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) u_dut_a (
        .clk(clk), .reset(reset), .req(req && !sel), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_a), .rdata(rdata_a), .err(err_a), .load_en(load_en && !sel),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_a)
    );

    mem_responder #(.ADDR_W(8), .DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B)) u_dut_b (
        .clk(clk), .reset(reset), .req(req && sel), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_b), .rdata(rdata_b), .err(err_b), .load_en(load_en && sel),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_b)
    );

    assign ack   = sel ? ack_b   : ack_a;
    assign err   = sel ? err_b   : err_a;
    assign busy  = sel ? busy_b  : busy_a;
    assign rdata = sel ? rdata_b : rdata_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (sel=%0d t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    function automatic int dep();
        return sel ? DEPTH_B : DEPTH_A;
    endfunction

    function automatic int wait_of();
        return sel ? WAIT_B : WAIT_A;
    endfunction

    // Called at a negedge with the selected instance idle; returns at a negedge.
    task automatic do_load(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        if (int'(a) < dep()) mem_m[sel][a] = d;
        check("load_no_ack", ack, 0);
        check("load_no_busy", busy, 0);
    endtask

    // One full handshake. in_rel: caller left the DUT in RELEASE (previous short_tail).
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input bit drop, input bit chg, input bit in_rel, input bit short_tail,
                       input bit ld, input logic [7:0] la, input logic [7:0] ldd);
        int   lat;
        int   hold;
        logic oor;
        req = 1'b1; we = w; addr = a; wdata = d;
        if (ld) begin load_en = 1'b1; load_addr = la; load_data = ldd; end
        if (in_rel) begin
            @(negedge clk);
            check("release_ignores_req", busy, 0);
        end
        if (ld) begin
            @(negedge clk);
            check("load_wins_busy", busy, 0);
            load_en = 1'b0;
            if (int'(la) < dep()) mem_m[sel][la] = ldd;
        end
        @(negedge clk);
        check("accept_busy", busy, 1);
        check("accept_ack", ack, 0);
        if (chg) begin
            addr = a + 8'd1; wdata = ~d; we = ~w;
            load_en = 1'b1; load_addr = a; load_data = ~d;
        end
        if (drop) req = 1'b0;
        lat = 0;
        while (ack !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        load_en = 1'b0;
        check("ack_latency", lat, wait_of() + 1);
        oor = (int'(a) >= dep());
        if (!w && !oor) rd_m[sel] = mem_m[sel][a];
        if (w && !oor) mem_m[sel][a] = d;
        check("err", err, oor);
        check("rdata", rdata, rd_m[sel]);
        if (!drop) begin
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge clk);
                check("hold_ack", ack, 1);
                check("hold_rdata", rdata, rd_m[sel]);
            end
            req = 1'b0;
        end
        @(negedge clk);
        check("release_ack", ack, 0);
        check("release_err", err, 0);
        check("release_busy", busy, 1);
        if (!short_tail) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end
    endtask

    // Reset lands exactly on the access edge of a write; req stays high through release.
    task automatic reset_mid_write(input logic [7:0] a, input logic [7:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        check("rst_accept_busy", busy, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1; we = 1'b0;
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 8'h00);
        rd_m[0] = 8'h00;
        rd_m[1] = 8'h00;
        reset = 1'b0;
    endtask

    task automatic random_phase(input int n);
        logic       w;
        logic [7:0] a, d, la, ldd;
        bit         drop, chg, sh, ld, prev_short;
        prev_short = 1'b0;
        for (int i = 0; i < n; i++) begin
            w    = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d    = 8'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            chg  = ($urandom_range(0, 3) == 0);
            sh   = (i != n - 1) && ($urandom_range(0, 3) == 0);
            ld   = !prev_short && ($urandom_range(0, 5) == 0);
            la   = 8'($urandom_range(0, 15));
            ldd  = 8'($urandom);
            txn(w, a, d, drop, chg, prev_short, sh, ld, la, ldd);
            prev_short = sh;
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("reset_ack", ack, 0);
            check("reset_err", err, 0);
            check("reset_busy", busy, 0);
            check("reset_rdata", rdata, 8'h00);
            rd_m[s] = 8'h00;
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < dep(); i++) do_load(8'(i), 8'($urandom));
        end

        // Instance A: DEPTH=128, two wait states.
        sel = 1'b0;
        do_load(8'h80, 8'hEE);
        do_load(8'hFF, 8'hEE);
        do_load(8'h10, 8'hA5);
        do_load(8'h11, 8'h5B);
        txn(1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        txn(1'b1, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        txn(1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        txn(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        txn(1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h11);
        txn(1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        do_load(8'h30, 8'h5A);
        reset_mid_write(8'h30, 8'h77);
        txn(1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        random_phase(60);

        // Instance B: DEPTH=256, zero wait states.
        sel = 1'b1;
        txn(1'b1, 8'h20, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        txn(1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        txn(1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        random_phase(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DEPTH, default 256, number of implemented bytes, 1..2^ADDR_W.
REQ-003 Parameter WAIT_CYCLES, default 2, wait states inserted before each response, 0..15.
REQ-004 Port clk, input, 1, clock, rising-edge active.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port req, input, 1, requester strobe for the four-phase handshake.
REQ-007 Port we, input, 1, 1=write, 0=read; valid while req=1.
REQ-008 Port addr, input, ADDR_W, byte address; valid while req=1.
REQ-009 Port wdata, input, 8, write data; valid while req=1.
REQ-010 Port ack, output, 1, response strobe.
REQ-011 Port rdata, output, 8, read data; valid while ack=1 and err=0 after a read.
REQ-012 Port err, output, 1, out-of-range flag; valid while ack=1.
REQ-013 Port load_en, input, 1, preload strobe for program/data image.
REQ-014 Port load_addr, input, ADDR_W, preload address.
REQ-015 Port load_data, input, 8, preload data.
REQ-016 Port busy, output, 1, high in every state except IDLE.

Function
REQ-017 Storage SHALL be DEPTH x 8-bit registers; contents SHALL NOT be cleared by reset.
REQ-018 FSM states SHALL be IDLE, WAIT, RESP, RELEASE; all outputs registered.
REQ-019 IDLE: req=1 and load_en=0 at edge N -> latch we/addr/wdata, load wait counter with WAIT_CYCLES, go to WAIT.
REQ-020 WAIT: counter decrements each edge; at the edge where counter equals 0, perform the access, assert ack, go to RESP; ack first high in the cycle after edge N+1+WAIT_CYCLES (WAIT_CYCLES=0 -> ack high after edge N+1).
REQ-021 Access on read: rdata <= mem[latched addr]; on write: mem[latched addr] <= latched wdata, rdata unchanged.
REQ-022 Latched addr >= DEPTH: no write, rdata unchanged, err=1 together with ack.
REQ-023 RESP: ack, err and rdata held stable while req=1; req sampled 0 -> ack<=0, err<=0, go to RELEASE.
REQ-024 RELEASE: one-cycle turnaround, then IDLE; a req=1 in RELEASE is not accepted until IDLE.
REQ-025 Changes to addr/we/wdata after acceptance SHALL be ignored.
REQ-026 req dropped during WAIT: access still completes, ack pulses one cycle in RESP, then RELEASE.
REQ-027 load_en=1 in IDLE: mem[load_addr] <= load_data if load_addr < DEPTH, otherwise ignored; no ack.
REQ-028 load_en=1 and req=1 simultaneously in IDLE: load wins; req accepted on first IDLE edge with load_en=0.
REQ-029 load_en outside IDLE SHALL be ignored.
REQ-030 Read of the address written by the immediately preceding transaction SHALL return the new data.

Reset
REQ-031 reset=1 at an edge: state IDLE, ack=0, err=0, rdata=8'h00, busy=0, counter=0, from any state.
REQ-032 Reset mid-transaction aborts it; a pending write whose access edge coincides with reset SHALL NOT occur.
REQ-033 After reset release, req=1 held high is accepted as a new request on the first IDLE edge.

Verification
REQ-034 Preload 0x10<-0xA5, read 0x10, WAIT_CYCLES=2: req at edge N -> ack high after edge N+3, rdata=0xA5, err=0; req low -> ack low next edge, busy low two edges later.
REQ-035 Write 0x20<-0x3C then read 0x20 -> rdata=0x3C; WAIT_CYCLES=0 -> ack after edge N+1.
REQ-036 DEPTH=128, write 0x80<-0xFF -> ack with err=1; read 0x80 -> err=1, rdata unchanged; mem[0x00] unchanged.
REQ-037 Simultaneous load_en (0x05<-0x11) and read req 0x05 in IDLE -> load performed, read accepted one edge later, rdata=0x11.
REQ-038 Reset asserted in WAIT of write 0x30<-0x77 -> ack stays 0, busy 0 next cycle, later read 0x30 returns prior value.
REQ-039 addr changed 0x10->0x11 during WAIT of read -> rdata from 0x10; req dropped in WAIT -> single-cycle ack pulse.
